// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: pipeline-register bundles, width codes and FSM states for the memory stage
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} MEM_FSM;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ALUOutput;
    logic [31:0] rd2;
    logic [31:0] AddSum;
    logic [4:0]  write_reg;
    logic [4:0]  rd;
    logic        MemToReg;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        BranchSrc0;
    logic        branch;
  } MEM_STATE;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ALUOutput;
    logic [31:0] rdata;
    logic [4:0]  write_reg;
    logic [4:0]  rd;
    logic        MemToReg;
    logic        RegWrite;
  } WBACK_STATE;

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == 2'b00 ? 4'b0001 << a :
           f3[1:0] == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    return f3[1:0] == 2'b00 ? {4{d[7:0]}} : f3[1:0] == 2'b01 ? {2{d[15:0]}} : d;
  endfunction

  function automatic WBACK_STATE to_wb(input MEM_STATE m, input logic [31:0] d, input logic rw);
    WBACK_STATE w;
    w.pc        = m.pc;
    w.ALUOutput = m.ALUOutput;
    w.rdata     = d;
    w.write_reg = m.write_reg;
    w.rd        = m.rd;
    w.MemToReg  = m.MemToReg;
    w.RegWrite  = rw;
    return w;
  endfunction

  function automatic WBACK_STATE with_data(input WBACK_STATE p, input logic [31:0] d);
    WBACK_STATE w;
    w       = p;
    w.rdata = d;
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: shift the read word down to the accessed lane and sign/zero-extend it
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [31:0] sh;

  // Lane select then extension by width code; unknown codes pass the shifted word
  always_comb begin
    sh   = rdata >> {addr, 3'b000};
    data = func3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
           func3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
           func3 == F3_BU ? {24'b0, sh[7:0]} :
           func3 == F3_HU ? {16'b0, sh[15:0]} : sh;
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with request/grant/response data-memory handshake
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit LOAD_ACCESS_FAULT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  MEM_STATE    mem_in,
  input  logic [2:0]  mem_func3,
  output logic        wb_valid,
  input  logic        wb_ready,
  output WBACK_STATE  wb_out,
  output logic        pc_redirect,
  output logic [31:0] redirect_target,
  output logic        misaligned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  MEM_FSM      state;
  WBACK_STATE  pend;
  logic [2:0]  f3_q;
  logic [31:0] ext;
  logic        out_free;
  logic        accept;
  logic        is_mem;
  logic        mis;
  logic        redirect;

  assign out_free = !wb_valid || wb_ready;
  assign in_ready = state == IDLE && out_free;
  assign accept   = in_valid && in_ready;
  assign is_mem   = mem_in.MemRead || mem_in.MemWrite;
  assign mis      = LOAD_ACCESS_FAULT_EN && is_mem && is_misaligned(mem_func3, mem_in.ALUOutput[1:0]);
  assign redirect = accept && mem_in.BranchSrc0 && mem_in.branch;
  assign dmem_req = state == REQ;

  load_align u_align (
    .rdata (dmem_rdata),
    .addr  (pend.ALUOutput[1:0]),
    .func3 (f3_q),
    .data  (ext)
  );

  // Transaction FSM; pend carries the in-flight instruction and, in HOLD, its load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pend            <= '0;
      f3_q            <= '0;
      wb_out          <= '0;
      wb_valid        <= 1'b0;
      pc_redirect     <= 1'b0;
      redirect_target <= '0;
      misaligned      <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_be         <= '0;
      dmem_wdata      <= '0;
    end else begin
      pc_redirect     <= redirect;
      redirect_target <= redirect ? mem_in.AddSum : '0;
      misaligned      <= accept && mis;
      if (wb_valid && wb_ready) wb_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (!is_mem || mis) begin
            wb_out   <= to_wb(mem_in, '0, mem_in.RegWrite && !mis);
            wb_valid <= 1'b1;
          end else begin
            state      <= REQ;
            pend       <= to_wb(mem_in, '0, mem_in.RegWrite);
            f3_q       <= mem_func3;
            dmem_we    <= mem_in.MemWrite;
            dmem_addr  <= {mem_in.ALUOutput[31:2], 2'b00};
            dmem_be    <= byte_en(mem_func3, mem_in.ALUOutput[1:0]);
            dmem_wdata <= store_data(mem_func3, mem_in.rd2);
          end
        end
        REQ: if (dmem_gnt) state <= RESP;
        RESP: if (dmem_rvalid) begin
          pend.rdata <= ext;
          if (out_free) begin
            wb_out   <= with_data(pend, ext);
            wb_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: if (wb_ready) begin
          wb_out   <= pend;
          wb_valid <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
